// File: rtl/aes_coproc_responder.sv
// AES custom-instruction responder: decodes request strobes, runs one AES step
// on an internal STATE/KEY pair and drives the matching done strobes.
//
// Ports:
//   clk, res          clock, async active-high reset
//   *_e               ten request strobes from the core
//   aes_store, s1     store payload and target select (s1[0]: 0=STATE 1=KEY)
//   *_done            one per request, low stalls the core
//   aes_load          registered copy of STATE from the last Load
//
// The forward and inverse S-boxes are computed arithmetically (GF(2^8)
// inversion plus affine map), so no ROM image file has to be loaded.
module aes_coproc_responder (
    input  logic         clk,
    input  logic         res,
    input  logic         Store_AES_e,
    input  logic         Load_AES_e,
    input  logic         EN_Addround_e,
    input  logic         EN_shiftrows_e,
    input  logic         EN_SubBytes_e,
    input  logic         EN_SubMix_e,
    input  logic         DE_Addround_e,
    input  logic         DE_shiftrows_e,
    input  logic         DE_SubBytes_e,
    input  logic         DE_SubMix_e,
    input  logic [127:0] aes_store,
    input  logic [31:0]  s1,
    output logic         Store_AES_done,
    output logic         Load_AES_done,
    output logic         EN_Addround_done,
    output logic         EN_shiftrows_done,
    output logic         EN_SubBytes_done,
    output logic         EN_SubMix_done,
    output logic         DE_Addround_done,
    output logic         DE_shiftrows_done,
    output logic         DE_SubBytes_done,
    output logic         DE_SubMix_done,
    output logic [127:0] aes_load
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } fsm_t;

    typedef enum logic [3:0] {
        OP_STORE,
        OP_LOAD,
        OP_EN_ADD,
        OP_DE_ADD,
        OP_EN_SR,
        OP_DE_SR,
        OP_EN_SB,
        OP_DE_SB,
        OP_EN_SM,
        OP_DE_SM
    } op_t;

    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = f_xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as AES wants
    function automatic logic [7:0] f_ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = f_gmul(a, a);
        acc = sq;
        for (int k = 0; k < 6; k++) begin
            sq  = f_gmul(sq, sq);
            acc = f_gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] f_rotl(input logic [7:0] b,
                                          input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] f_aff(input logic [7:0] b);
        return b ^ f_rotl(b, 1) ^ f_rotl(b, 2) ^ f_rotl(b, 3)
                 ^ f_rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] f_iaff(input logic [7:0] b);
        return f_rotl(b, 1) ^ f_rotl(b, 3) ^ f_rotl(b, 6) ^ 8'h05;
    endfunction

    function automatic logic [127:0] f_shift(input logic [127:0] s,
                                             input logic inv);
        logic [127:0] o;
        int src;
        o = s;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] f_mix(input logic [31:0] c,
                                          input logic inv);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        if (inv) begin
            b0 = f_gmul(a0, 8'h0e) ^ f_gmul(a1, 8'h0b)
               ^ f_gmul(a2, 8'h0d) ^ f_gmul(a3, 8'h09);
            b1 = f_gmul(a0, 8'h09) ^ f_gmul(a1, 8'h0e)
               ^ f_gmul(a2, 8'h0b) ^ f_gmul(a3, 8'h0d);
            b2 = f_gmul(a0, 8'h0d) ^ f_gmul(a1, 8'h09)
               ^ f_gmul(a2, 8'h0e) ^ f_gmul(a3, 8'h0b);
            b3 = f_gmul(a0, 8'h0b) ^ f_gmul(a1, 8'h0d)
               ^ f_gmul(a2, 8'h09) ^ f_gmul(a3, 8'h0e);
        end else begin
            b0 = f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3;
            b1 = a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3;
            b2 = a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3;
            b3 = f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3);
        end
        return {b0, b1, b2, b3};
    endfunction

    fsm_t         r_fsm, w_fsm_nxt;
    op_t          r_op, w_op_nxt;
    op_t          w_sel;
    logic         w_any;
    logic [127:0] r_state, w_state_nxt;
    logic [127:0] r_key, w_key_nxt;
    logic [127:0] r_load, w_load_nxt;
    logic [3:0]   r_byte, w_byte_nxt;
    logic [1:0]   r_col, w_col_nxt;
    logic         r_mix, w_mix_nxt;
    logic [6:0]   w_bbase;
    logic [6:0]   w_cbase;
    logic         w_fwd;
    logic [7:0]   w_sb_in;
    logic [7:0]   w_ginv;
    logic [7:0]   w_sb_out;
    logic [31:0]  w_mix_out;
    logic         w_fin;
    logic         w_unused;

    assign w_unused = &{1'b0, s1[31:1]};

    // Highest-priority pending request
    always_comb begin
        w_any = 1'b1;
        w_sel = OP_STORE;
        if (Store_AES_e)         w_sel = OP_STORE;
        else if (Load_AES_e)     w_sel = OP_LOAD;
        else if (EN_Addround_e)  w_sel = OP_EN_ADD;
        else if (DE_Addround_e)  w_sel = OP_DE_ADD;
        else if (EN_shiftrows_e) w_sel = OP_EN_SR;
        else if (DE_shiftrows_e) w_sel = OP_DE_SR;
        else if (EN_SubBytes_e)  w_sel = OP_EN_SB;
        else if (DE_SubBytes_e)  w_sel = OP_DE_SB;
        else if (EN_SubMix_e)    w_sel = OP_EN_SM;
        else if (DE_SubMix_e)    w_sel = OP_DE_SM;
        else                     w_any = 1'b0;
    end

    // One shared inverter serves both S-box directions
    assign w_bbase   = 7'd127 - {r_byte, 3'b000};
    assign w_cbase   = 7'd127 - {r_col, 5'b00000};
    assign w_fwd     = (r_op == OP_EN_SB) || (r_op == OP_EN_SM);
    assign w_sb_in   = r_state[w_bbase -: 8];
    assign w_ginv    = f_ginv(w_fwd ? w_sb_in : f_iaff(w_sb_in));
    assign w_sb_out  = w_fwd ? f_aff(w_ginv) : w_ginv;
    assign w_mix_out = f_mix(r_state[w_cbase -: 32], r_op == OP_DE_SM);

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_op_nxt    = r_op;
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_load_nxt  = r_load;
        w_byte_nxt  = r_byte;
        w_col_nxt   = r_col;
        w_mix_nxt   = r_mix;
        unique case (r_fsm)
            ST_IDLE: begin
                if (w_any) begin
                    w_op_nxt  = w_sel;
                    w_fsm_nxt = ST_DONE;
                    unique case (w_sel)
                        OP_STORE: begin
                            if (s1[0]) w_key_nxt   = aes_store;
                            else       w_state_nxt = aes_store;
                        end
                        OP_LOAD:   w_load_nxt  = r_state;
                        OP_EN_ADD,
                        OP_DE_ADD: w_state_nxt = r_state ^ r_key;
                        OP_EN_SR:  w_state_nxt = f_shift(r_state, 1'b0);
                        OP_DE_SR:  w_state_nxt = f_shift(r_state, 1'b1);
                        default: begin
                            w_fsm_nxt  = ST_BUSY;
                            w_byte_nxt = 4'd0;
                            w_col_nxt  = 2'd0;
                            // InvSubMix starts with the column pass
                            w_mix_nxt  = (w_sel == OP_DE_SM);
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                if (r_mix) begin
                    w_state_nxt[w_cbase -: 32] = w_mix_out;
                    if (r_col == 2'd3) begin
                        w_col_nxt = 2'd0;
                        if (r_op == OP_DE_SM) begin
                            w_mix_nxt  = 1'b0;
                            w_byte_nxt = 4'd0;
                        end else begin
                            w_fsm_nxt = ST_DONE;
                        end
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end else begin
                    w_state_nxt[w_bbase -: 8] = w_sb_out;
                    if (r_byte == 4'd15) begin
                        w_byte_nxt = 4'd0;
                        if (r_op == OP_EN_SM) begin
                            w_mix_nxt = 1'b1;
                            w_col_nxt = 2'd0;
                        end else begin
                            w_fsm_nxt = ST_DONE;
                        end
                    end else begin
                        w_byte_nxt = r_byte + 4'd1;
                    end
                end
            end
            ST_DONE: w_fsm_nxt = ST_IDLE;
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_fsm <= ST_IDLE;
            r_op  <= OP_STORE;
        end else begin
            r_fsm <= w_fsm_nxt;
            r_op  <= w_op_nxt;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= '0;
            r_key   <= '0;
            r_load  <= '0;
            r_byte  <= '0;
            r_col   <= '0;
            r_mix   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_load  <= w_load_nxt;
            r_byte  <= w_byte_nxt;
            r_col   <= w_col_nxt;
            r_mix   <= w_mix_nxt;
        end
    end

    assign w_fin    = (r_fsm == ST_DONE);
    assign aes_load = r_load;

    assign Store_AES_done    = !(Store_AES_e    && !(w_fin && r_op == OP_STORE));
    assign Load_AES_done     = !(Load_AES_e     && !(w_fin && r_op == OP_LOAD));
    assign EN_Addround_done  = !(EN_Addround_e  && !(w_fin && r_op == OP_EN_ADD));
    assign DE_Addround_done  = !(DE_Addround_e  && !(w_fin && r_op == OP_DE_ADD));
    assign EN_shiftrows_done = !(EN_shiftrows_e && !(w_fin && r_op == OP_EN_SR));
    assign DE_shiftrows_done = !(DE_shiftrows_e && !(w_fin && r_op == OP_DE_SR));
    assign EN_SubBytes_done  = !(EN_SubBytes_e  && !(w_fin && r_op == OP_EN_SB));
    assign DE_SubBytes_done  = !(DE_SubBytes_e  && !(w_fin && r_op == OP_DE_SB));
    assign EN_SubMix_done    = !(EN_SubMix_e    && !(w_fin && r_op == OP_EN_SM));
    assign DE_SubMix_done    = !(DE_SubMix_e    && !(w_fin && r_op == OP_DE_SM));

endmodule

// File: tb/tb_aes_coproc_responder.sv
// Directed bench for aes_coproc_responder: known AES vectors, done
// latencies, reset mid-operation and request priority.
module tb_aes_coproc_responder;

    logic         clk = 1'b0;
    logic         res;
    logic [9:0]   req;
    logic [9:0]   dn;
    logic [127:0] aes_store;
    logic [31:0]  s1;
    logic [127:0] aes_load;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    // req/dn bit order follows the request priority
    aes_coproc_responder dut (
        .clk               (clk),
        .res               (res),
        .Store_AES_e       (req[0]),
        .Load_AES_e        (req[1]),
        .EN_Addround_e     (req[2]),
        .DE_Addround_e     (req[3]),
        .EN_shiftrows_e    (req[4]),
        .DE_shiftrows_e    (req[5]),
        .EN_SubBytes_e     (req[6]),
        .DE_SubBytes_e     (req[7]),
        .EN_SubMix_e       (req[8]),
        .DE_SubMix_e       (req[9]),
        .aes_store         (aes_store),
        .s1                (s1),
        .Store_AES_done    (dn[0]),
        .Load_AES_done     (dn[1]),
        .EN_Addround_done  (dn[2]),
        .DE_Addround_done  (dn[3]),
        .EN_shiftrows_done (dn[4]),
        .DE_shiftrows_done (dn[5]),
        .EN_SubBytes_done  (dn[6]),
        .DE_SubBytes_done  (dn[7]),
        .EN_SubMix_done    (dn[8]),
        .DE_SubMix_done    (dn[9]),
        .aes_load          (aes_load)
    );

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Raise one request in an IDLE cycle (T0), count cycles to done
    task automatic run_op(input int idx, input int lat, input string tag);
        int n;
        bit got;
        @(posedge clk);
        @(negedge clk);
        req[idx] = 1'b1;
        #1;
        check({tag, "_t0"}, {127'b0, dn[idx]}, 128'd0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            got = dn[idx];
        end
        check({tag, "_lat"}, n, lat);
        req[idx] = 1'b0;
    endtask

    task automatic store(input logic [127:0] d, input bit key,
                         input string tag);
        aes_store = d;
        s1        = {31'b0, key};
        run_op(0, 1, tag);
    endtask

    task automatic load_chk(input logic [127:0] exp, input string tag);
        run_op(1, 1, {tag, "_ld"});
        check(tag, aes_load, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res       = 1'b1;
        req       = '0;
        aes_store = '0;
        s1        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", {118'b0, dn}, 128'h3ff);
        check("reset_load", aes_load, 128'd0);
        @(negedge clk);
        res = 1'b0;

        store(128'h000102030405060708090a0b0c0d0e0f, 1'b0, "st_seq");
        load_chk(128'h000102030405060708090a0b0c0d0e0f, "load_seq");

        run_op(4, 1, "en_sr");
        load_chk(128'h00050a0f04090e03080d02070c01060b, "en_sr_val");
        run_op(5, 1, "de_sr");
        load_chk(128'h000102030405060708090a0b0c0d0e0f, "de_sr_val");

        store(128'd0, 1'b0, "st_zero");
        run_op(6, 17, "en_sb");
        load_chk({16{8'h63}}, "en_sb_val");

        store({32'h9f825068, 96'd0}, 1'b0, "st_mix");
        run_op(8, 21, "en_sm");
        load_chk({32'h8e4da1bc, {12{8'h63}}}, "en_sm_val");
        run_op(9, 21, "de_sm");
        load_chk({32'h9f825068, 96'd0}, "de_sm_val");

        store(128'h3243f6a8885a308d313198a2e0370734, 1'b0, "st_pt");
        store(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, "st_key");
        load_chk(128'h3243f6a8885a308d313198a2e0370734, "key_keeps_st");
        run_op(2, 1, "en_add");
        load_chk(128'h193de3bea0f4e22b9ac68d2ae9f84808, "en_add_val");
        run_op(3, 1, "de_add");
        load_chk(128'h3243f6a8885a308d313198a2e0370734, "de_add_val");

        // Reset while EN_SubBytes is at byte counter 8
        @(posedge clk);
        @(negedge clk);
        req[6] = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        check("busy_mid", {127'b0, dn[6]}, 128'd0);
        #1;
        res = 1'b1;
        req = '0;
        #1;
        check("rst_mid_done", {118'b0, dn}, 128'h3ff);
        check("rst_mid_load", aes_load, 128'd0);
        @(negedge clk);
        res = 1'b0;
        load_chk(128'd0, "rst_state");

        // Store and Load together: Store wins, Load waits its turn
        @(posedge clk);
        @(negedge clk);
        aes_store = 128'hdeadbeef00112233445566778899aabb;
        s1        = '0;
        req[0]    = 1'b1;
        req[1]    = 1'b1;
        #1;
        check("sl_t0", {126'b0, dn[1:0]}, 128'd0);
        @(posedge clk);
        #1;
        check("sl_store", {127'b0, dn[0]}, 128'd1);
        check("sl_ld_wait", {127'b0, dn[1]}, 128'd0);
        req[0] = 1'b0;
        @(posedge clk);
        #1;
        check("sl_ld_idle", {127'b0, dn[1]}, 128'd0);
        @(posedge clk);
        #1;
        check("sl_ld_done", {127'b0, dn[1]}, 128'd1);
        check("sl_data", aes_load, 128'hdeadbeef00112233445566778899aabb);
        req[1] = 1'b0;

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
